// File: rtl/dff_delay_line_pkg.sv
// rtl/dff_delay_line_pkg.sv - shared operation encoding and index-width helper for the delay line
package dff_delay_line_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_SHIFT = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLR   = 2'd3
  } op_e;

  // Width needed to index n items; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// rtl/dff_stage.sv - one data+valid register stage with update strobe and async reset
module dff_stage #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic             upd,
  input  logic [WIDTH-1:0] d_next,
  input  logic             v_next,
  output logic [WIDTH-1:0] q,
  output logic             v
);

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      q <= RST_VAL;
      v <= 1'b0;
    end else if (upd) begin
      q <= d_next;
      v <= v_next;
    end
  end

endmodule

// File: rtl/dff_delay_line.sv
// rtl/dff_delay_line.sv - DEPTH-stage shift line with clear, parallel load, tap mux and fill counter
module dff_delay_line
  import dff_delay_line_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                              clk,
  input  logic                              async_reset,
  input  logic                              en,
  input  logic                              sync_clr,
  input  logic                              load,
  input  logic [WIDTH*DEPTH-1:0]            load_data,
  input  logic [WIDTH-1:0]                  din,
  input  logic                              din_valid,
  input  logic [sel_width(DEPTH)-1:0]       tap_sel,
  output logic [WIDTH-1:0]                  dout,
  output logic                              dout_valid,
  output logic [WIDTH-1:0]                  tap_out,
  output logic                              tap_valid,
  output logic [sel_width(DEPTH+1)-1:0]     fill_count
);

  localparam int TSW = sel_width(DEPTH);
  localparam int FCW = sel_width(DEPTH + 1);

  op_e              op;
  logic             upd;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_valid;

  always_comb begin
    if (sync_clr)  op = OP_CLR;
    else if (load) op = OP_LOAD;
    else if (en)   op = OP_SHIFT;
    else           op = OP_HOLD;
  end

  assign upd = (op != OP_HOLD);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] shift_d;
    logic             shift_v;
    logic [WIDTH-1:0] d_next;
    logic             v_next;

    if (i == 0) begin : g_head
      assign shift_d = din;
      assign shift_v = din_valid;
    end else begin : g_body
      assign shift_d = stage_data[i-1];
      assign shift_v = stage_valid[i-1];
    end

    always_comb begin
      case (op)
        OP_CLR: begin
          d_next = RST_VAL;
          v_next = 1'b0;
        end
        OP_LOAD: begin
          d_next = load_data[i*WIDTH +: WIDTH];
          v_next = 1'b1;
        end
        default: begin
          d_next = shift_d;
          v_next = shift_v;
        end
      endcase
    end

    dff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk         (clk),
      .async_reset (async_reset),
      .upd         (upd),
      .d_next      (d_next),
      .v_next      (v_next),
      .q           (stage_data[i]),
      .v           (stage_valid[i])
    );
  end

  // Counter tracks popcount of valid flags incrementally; modulo arithmetic
  // keeps the transient +1 harmless when the line is full.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      fill_count <= '0;
    end else begin
      case (op)
        OP_CLR:   fill_count <= '0;
        OP_LOAD:  fill_count <= FCW'(DEPTH);
        OP_SHIFT: fill_count <= fill_count + FCW'(din_valid) - FCW'(stage_valid[DEPTH-1]);
        default:  fill_count <= fill_count;
      endcase
    end
  end

  assign dout       = stage_data[DEPTH-1];
  assign dout_valid = stage_valid[DEPTH-1];

  always_comb begin
    tap_out   = RST_VAL;
    tap_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TSW'(i)) begin
        tap_out   = stage_data[i];
        tap_valid = stage_valid[i];
      end
    end
  end

endmodule

// File: tb/tb_dff_delay_line.sv
// tb/tb_dff_delay_line.sv - directed-vector bench for dff_delay_line (DEPTH=4 and DEPTH=3 builds)
module tb_dff_delay_line;

  logic        clk = 1'b0;
  logic        async_reset;
  logic        en, sync_clr, load, din_valid;
  logic [7:0]  din;
  logic [31:0] load_data;
  logic [1:0]  tap_sel;
  logic [7:0]  dout, tap_out;
  logic        dout_valid, tap_valid;
  logic [2:0]  fill_count;

  logic [23:0] b_load_data;
  logic [1:0]  b_tap_sel;
  logic [7:0]  b_dout, b_tap_out;
  logic        b_dout_valid, b_tap_valid;
  logic [1:0]  b_fill_count;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  dff_delay_line #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut_a (
    .clk(clk), .async_reset(async_reset), .en(en), .sync_clr(sync_clr), .load(load),
    .load_data(load_data), .din(din), .din_valid(din_valid), .tap_sel(tap_sel),
    .dout(dout), .dout_valid(dout_valid), .tap_out(tap_out), .tap_valid(tap_valid),
    .fill_count(fill_count)
  );

  dff_delay_line #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5)) dut_b (
    .clk(clk), .async_reset(async_reset), .en(en), .sync_clr(sync_clr), .load(load),
    .load_data(b_load_data), .din(din), .din_valid(din_valid), .tap_sel(b_tap_sel),
    .dout(b_dout), .dout_valid(b_dout_valid), .tap_out(b_tap_out), .tap_valid(b_tap_valid),
    .fill_count(b_fill_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [7:0] d, input logic dv, input logic [2:0] fc);
    check({tag, ".dout"}, 32'(dout), 32'(d));
    check({tag, ".dout_valid"}, 32'(dout_valid), 32'(dv));
    check({tag, ".fill"}, 32'(fill_count), 32'(fc));
  endtask

  logic [7:0] exp_dout [4];
  logic [2:0] exp_fill [4];
  logic       exp_en   [4];
  logic [7:0] tap_exp  [4];

  initial begin
    async_reset = 1'b1;
    en = 0; sync_clr = 0; load = 0; din_valid = 0; din = 8'h00;
    load_data = 32'h0; tap_sel = 2'd0; b_load_data = 24'h0; b_tap_sel = 2'd0;
    #1;
    check_a("reset", 8'h00, 1'b0, 3'd0);
    check("reset.b_dout", 32'(b_dout), 32'hA5);
    check("reset.b_dout_valid", 32'(b_dout_valid), 32'h0);

    // Reset holds state even with load requested across an edge.
    load = 1; load_data = 32'hDEADBEEF;
    tick();
    check_a("reset_ignores_load", 8'h00, 1'b0, 3'd0);
    load = 0;
    #3 async_reset = 1'b0;

    // Fill with four valid words.
    en = 1; din_valid = 1;
    din = 8'h11; tick(); check("fill1.fill", 32'(fill_count), 32'd1);
    din = 8'h22; tick(); check("fill2.fill", 32'(fill_count), 32'd2);
    din = 8'h33; tick(); check_a("fill3", 8'h00, 1'b0, 3'd3);
    din = 8'h44; tick(); check_a("fill4", 8'h11, 1'b1, 3'd4);

    // Enable pattern 1,0,0,1 with invalid words.
    exp_en   = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_dout = '{8'h22, 8'h22, 8'h22, 8'h33};
    exp_fill = '{3'd3, 3'd3, 3'd3, 3'd2};
    din_valid = 0;
    for (int k = 0; k < 4; k++) begin
      en  = exp_en[k];
      din = 8'h55 + 8'(k * 8'h11);
      tick();
      check_a($sformatf("gate%0d", k), exp_dout[k], 1'b1, exp_fill[k]);
    end
    check("gate.tap0_data", 32'(tap_out), 32'h88);
    check("gate.tap0_valid", 32'(tap_valid), 32'h0);

    // Load wins over en; din ignored.
    en = 1; din = 8'hEE; din_valid = 1;
    load = 1; load_data = 32'h44332211; b_load_data = 24'h332211;
    tick();
    load = 0; en = 0;
    check_a("load", 8'h44, 1'b1, 3'd4);
    tap_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      tap_sel = 2'(k);
      #1;
      check($sformatf("tap%0d.data", k), 32'(tap_out), 32'(tap_exp[k]));
      check($sformatf("tap%0d.valid", k), 32'(tap_valid), 32'h1);
    end
    b_tap_sel = 2'd3; #1;
    check("b_tap3.data", 32'(b_tap_out), 32'hA5);
    check("b_tap3.valid", 32'(b_tap_valid), 32'h0);
    b_tap_sel = 2'd2; #1;
    check("b_tap2.data", 32'(b_tap_out), 32'h33);
    check("b.fill", 32'(b_fill_count), 32'd3);

    // Clear wins over load and en.
    sync_clr = 1; load = 1; en = 1;
    tick();
    sync_clr = 0; load = 0; en = 0;
    check_a("clr", 8'h00, 1'b0, 3'd0);
    tap_sel = 2'd1; #1;
    check("clr.tap1_valid", 32'(tap_valid), 32'h0);
    check("clr.b_dout", 32'(b_dout), 32'hA5);

    // Async reset pulse between edges on a full line.
    load = 1; load_data = 32'h44332211;
    tick();
    load = 0;
    check_a("reload", 8'h44, 1'b1, 3'd4);
    en = 1; din = 8'h99; din_valid = 1;
    #2 async_reset = 1'b1;
    #1 check_a("async_pulse", 8'h00, 1'b0, 3'd0);
    #1 async_reset = 1'b0;
    tick();
    en = 0;
    check_a("post_reset_shift", 8'h00, 1'b0, 3'd1);
    tap_sel = 2'd0; #1;
    check("post_reset.tap0_data", 32'(tap_out), 32'h99);
    check("post_reset.tap0_valid", 32'(tap_valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
